load_use_scoreboard: RTL and testbench

Parametrised successor to the single-cycle load-use hazard detector. It tracks load destination registers still in flight for a configurable memory latency and raises stall while an ID-stage source depends on a load that cannot yet be forwarded. It also ignores x0, qualifies each source with a use bit, and honours flush. It sits between the ID/EX pipeline registers and the PC/IF-ID enable logic.

---
 rtl/load_use_scoreboard_if.sv | 47 ++++
 rtl/load_use_scoreboard.sv | 88 ++++++++
 tb/tb_load_use_scoreboard.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_use_scoreboard_if.sv
// Load-use scoreboard bus: EX/ID hazard inputs and stall/hazard results.
// Optional stall_cycles member is present only with HAZARD_STALL_COUNTER_EN defined.
// Pure wiring, no latency, no backpressure.
interface load_use_scoreboard_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      EX_valid;
    logic                      EX_mem_to_reg;
    logic [REG_ADDR_WIDTH-1:0] EX_destination_register;
    logic [REG_ADDR_WIDTH-1:0] ID_read_register_0;
    logic [REG_ADDR_WIDTH-1:0] ID_read_register_1;
    logic                      ID_uses_register_0;
    logic                      ID_uses_register_1;
    logic                      flush;
    logic                      stall;
    logic                      hazard_register_0;
    logic                      hazard_register_1;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0]               stall_cycles;

    modport master (
        output EX_valid, EX_mem_to_reg, EX_destination_register,
               ID_read_register_0, ID_read_register_1,
               ID_uses_register_0, ID_uses_register_1, flush,
        input  stall, hazard_register_0, hazard_register_1, stall_cycles
    );
    modport slave (
        input  EX_valid, EX_mem_to_reg, EX_destination_register,
               ID_read_register_0, ID_read_register_1,
               ID_uses_register_0, ID_uses_register_1, flush,
        output stall, hazard_register_0, hazard_register_1, stall_cycles
    );
`else
    modport master (
        output EX_valid, EX_mem_to_reg, EX_destination_register,
               ID_read_register_0, ID_read_register_1,
               ID_uses_register_0, ID_uses_register_1, flush,
        input  stall, hazard_register_0, hazard_register_1
    );
    modport slave (
        input  EX_valid, EX_mem_to_reg, EX_destination_register,
               ID_read_register_0, ID_read_register_1,
               ID_uses_register_0, ID_uses_register_1, flush,
        output stall, hazard_register_0, hazard_register_1
    );
`endif
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: stalls ID while a source waits on an in-flight load.
// Latency: outputs combinational (zero cycle); LOAD_LATENCY-1 tracking slots.
// No backpressure; stall is the backpressure it produces. HAZARD_STALL_COUNTER_EN adds stall_cycles.
module load_use_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    load_use_scoreboard_if.slave bus
);
    localparam int NSLOT = LOAD_LATENCY - 1;

    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [REG_ADDR_WIDTH-1:0] rs0;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic                      ex_load;
    logic                      slot_hit_0;
    logic                      slot_hit_1;
    logic                      match_0;
    logic                      match_1;
    logic                      hazard_0;
    logic                      hazard_1;

    assign ex_rd   = bus.EX_destination_register;
    assign rs0     = bus.ID_read_register_0;
    assign rs1     = bus.ID_read_register_1;
    // Loads to x0 never produce a value anyone waits on, so they are not tracked.
    assign ex_load = bus.EX_valid && bus.EX_mem_to_reg && (ex_rd != '0);

    if (NSLOT > 0) begin : g_slots
        logic [NSLOT-1:0]          slot_vld;
        logic [REG_ADDR_WIDTH-1:0] slot_rd [NSLOT];

        // Slots age every cycle even while stalled; flush does not touch loads past EX.
        always_ff @(posedge clk) begin
            if (rst) begin
                slot_vld <= '0;
            end else begin
                slot_vld[0] <= ex_load;
                for (int k = 1; k < NSLOT; k++) begin
                    slot_vld[k] <= slot_vld[k-1];
                end
            end
            slot_rd[0] <= ex_rd;
            for (int k = 1; k < NSLOT; k++) begin
                slot_rd[k] <= slot_rd[k-1];
            end
        end

        always_comb begin
            slot_hit_0 = 1'b0;
            slot_hit_1 = 1'b0;
            for (int k = 0; k < NSLOT; k++) begin
                if (slot_vld[k] && (slot_rd[k] == rs0)) slot_hit_0 = 1'b1;
                if (slot_vld[k] && (slot_rd[k] == rs1)) slot_hit_1 = 1'b1;
            end
        end
    end else begin : g_no_slots
        assign slot_hit_0 = 1'b0;
        assign slot_hit_1 = 1'b0;
    end

    assign match_0  = bus.ID_uses_register_0 && (rs0 != '0) &&
                      ((ex_load && (ex_rd == rs0)) || slot_hit_0);
    assign match_1  = bus.ID_uses_register_1 && (rs1 != '0) &&
                      ((ex_load && (ex_rd == rs1)) || slot_hit_1);
    assign hazard_0 = match_0 && !bus.flush;
    assign hazard_1 = match_1 && !bus.flush;

    assign bus.hazard_register_0 = hazard_0;
    assign bus.hazard_register_1 = hazard_1;
    assign bus.stall             = hazard_0 | hazard_1;

`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard_0 | hazard_1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard at LOAD_LATENCY 1..4 sharing one stimulus stream,
// checked against a cycle-history model of in-flight loads.
module tb_load_use_scoreboard;
    logic       clk = 1'b0;
    logic       rst_i;
    logic       ex_valid, ex_m2r, use0, use1, flush;
    logic [4:0] ex_rd, rs0, rs1;

    logic [3:0] stall_v, h0_v, h1_v;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] cnt_v [4];
    int          cnt_m [4];
    bit          cnt_known;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        load_use_scoreboard_if u_if ();
        assign u_if.EX_valid                = ex_valid;
        assign u_if.EX_mem_to_reg           = ex_m2r;
        assign u_if.EX_destination_register = ex_rd;
        assign u_if.ID_read_register_0      = rs0;
        assign u_if.ID_read_register_1      = rs1;
        assign u_if.ID_uses_register_0      = use0;
        assign u_if.ID_uses_register_1      = use1;
        assign u_if.flush                   = flush;
        assign stall_v[g] = u_if.stall;
        assign h0_v[g]    = u_if.hazard_register_0;
        assign h1_v[g]    = u_if.hazard_register_1;
`ifdef HAZARD_STALL_COUNTER_EN
        assign cnt_v[g]   = u_if.stall_cycles;
`endif
        load_use_scoreboard #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(g + 1)) u_dut (
            .clk (clk),
            .rst (rst_i),
            .bus (u_if)
        );
    end

    int n_vec = 0;
    int n_err = 0;

    // Model state: destination of the load seen in EX at each absolute cycle (-1 none).
    int ld_hist [1024];
    int cyc      = 0;
    int last_rst = -1;
    logic [3:0] obs_s, obs_0, obs_1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A load issued j cycles ago is still unforwardable for j < L unless a reset came since.
    function automatic bit in_flight(int lat, int cur, int rs);
        if (cur == rs) return 1'b1;
        for (int j = 1; j < lat; j++) begin
            if (cyc - j > last_rst && ld_hist[cyc-j] == rs) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_cycle();
        int cur;
        bit e0, e1;
        #3;
        cur = (ex_valid && ex_m2r && ex_rd != 5'd0) ? int'(ex_rd) : -1;
        obs_s = stall_v;
        obs_0 = h0_v;
        obs_1 = h1_v;
        for (int L = 1; L <= 4; L++) begin
            e0 = use0 && rs0 != 5'd0 && !flush && in_flight(L, cur, int'(rs0));
            e1 = use1 && rs1 != 5'd0 && !flush && in_flight(L, cur, int'(rs1));
            chk($sformatf("c%0d_L%0d_hz0", cyc, L), {31'd0, h0_v[L-1]}, {31'd0, e0});
            chk($sformatf("c%0d_L%0d_hz1", cyc, L), {31'd0, h1_v[L-1]}, {31'd0, e1});
            chk($sformatf("c%0d_L%0d_stall", cyc, L), {31'd0, stall_v[L-1]}, {31'd0, e0 | e1});
`ifdef HAZARD_STALL_COUNTER_EN
            if (cnt_known)
                chk($sformatf("c%0d_L%0d_cnt", cyc, L), cnt_v[L-1], cnt_m[L-1]);
            if (rst_i) cnt_m[L-1] = 0;
            else if (e0 | e1) cnt_m[L-1] = cnt_m[L-1] + 1;
`endif
        end
`ifdef HAZARD_STALL_COUNTER_EN
        if (rst_i) cnt_known = 1'b1;
`endif
        ld_hist[cyc] = cur;
        if (rst_i) last_rst = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic m, input logic [4:0] rd);
        ex_valid = v;
        ex_m2r   = m;
        ex_rd    = rd;
    endtask

    task automatic set_id(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
        rs0  = a;
        use0 = ua;
        rs1  = b;
        use1 = ub;
    endtask

    task automatic idle(input int n);
        set_ex(1'b0, 1'b0, 5'd0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int len1, len3, len4;
        rst_i = 1'b1;
        flush = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        chk("reset_stall", {28'd0, obs_s}, 32'd0);
        chk("reset_hz", {24'd0, obs_0, obs_1}, 32'd0);
        rst_i = 1'b0;
        idle(1);

        // Single load rd=5 consumed by rs1 of the next instruction.
        set_ex(1'b1, 1'b1, 5'd5);
        set_id(5'd5, 1'b1, 5'd0, 1'b0);
        run_cycle();
        chk("A_c0_L1_stall", {31'd0, obs_s[0]}, 32'd1);
        chk("A_c0_L1_hz0", {31'd0, obs_0[0]}, 32'd1);
        set_ex(1'b0, 1'b0, 5'd0);
        run_cycle();
        chk("A_c1_L1_stall", {31'd0, obs_s[0]}, 32'd0);
        idle(4);

        // Load rd=7, rs2 held in ID: stall lasts exactly LOAD_LATENCY cycles.
        len1 = 0; len3 = 0; len4 = 0;
        set_ex(1'b1, 1'b1, 5'd7);
        set_id(5'd0, 1'b0, 5'd7, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            set_ex(1'b0, 1'b0, 5'd0);
            len1 += int'(obs_s[0]);
            len3 += int'(obs_s[2]);
            len4 += int'(obs_s[3]);
            if (obs_s[2]) chk("B_L3_hz1", {31'd0, obs_1[2]}, 32'd1);
        end
        chk("B_L1_len", len1, 1);
        chk("B_L3_len", len3, 3);
        chk("B_L4_len", len4, 4);
        idle(4);

        // x0 never stalls; unused source never stalls.
        set_ex(1'b1, 1'b1, 5'd0);
        set_id(5'd0, 1'b1, 5'd0, 1'b1);
        run_cycle();
        chk("C_x0_stall", {28'd0, obs_s}, 32'd0);
        set_ex(1'b1, 1'b1, 5'd9);
        set_id(5'd9, 1'b0, 5'd0, 1'b0);
        run_cycle();
        chk("C_unused_stall", {28'd0, obs_s}, 32'd0);
        idle(4);

        // Back-to-back loads rd=3, rd=4 at LOAD_LATENCY=2 with rs1=3, rs2=4.
        set_id(5'd3, 1'b1, 5'd4, 1'b1);
        set_ex(1'b1, 1'b1, 5'd3);
        run_cycle();
        chk("D_c0_L2", {30'd0, obs_0[1], obs_1[1]}, 32'b10);
        set_ex(1'b1, 1'b1, 5'd4);
        run_cycle();
        chk("D_c1_L2", {30'd0, obs_0[1], obs_1[1]}, 32'b11);
        set_ex(1'b0, 1'b0, 5'd0);
        run_cycle();
        chk("D_c2_L2", {30'd0, obs_0[1], obs_1[1]}, 32'b01);
        chk("D_c2_L2_stall", {31'd0, obs_s[1]}, 32'd1);
        run_cycle();
        chk("D_c3_L2_stall", {31'd0, obs_s[1]}, 32'd0);
        idle(4);

        // Flush masks a real dependency.
        set_ex(1'b1, 1'b1, 5'd8);
        set_id(5'd8, 1'b1, 5'd8, 1'b1);
        flush = 1'b1;
        run_cycle();
        chk("E_flush_stall", {28'd0, obs_s}, 32'd0);
        flush = 1'b0;
        idle(4);

        // Reset in the middle of a LOAD_LATENCY=4 stall.
        set_ex(1'b1, 1'b1, 5'd6);
        set_id(5'd6, 1'b1, 5'd0, 1'b0);
        run_cycle();
        set_ex(1'b0, 1'b0, 5'd0);
        run_cycle();
        chk("F_c1_L4_stall", {31'd0, obs_s[3]}, 32'd1);
        rst_i = 1'b1;
        run_cycle();
        chk("F_rst_L4_stall", {31'd0, obs_s[3]}, 32'd1);
        rst_i = 1'b0;
        run_cycle();
        chk("F_after_L4_stall", {31'd0, obs_s[3]}, 32'd0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)));
            set_id(5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
            flush = 1'($urandom_range(0, 15) == 0);
            rst_i = 1'($urandom_range(0, 39) == 0);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
